// File: rtl/sig_acq_pkg.sv
// Shared constants for the signal-acquisition UART path: arbiter state encoding and TX FIFO depth.
package sig_acq_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_CSUM = 2'd2
  } arb_state_t;

  localparam int UART_FIFO_DEPTH = 32;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set bit of req searching upward from last+1 with wrap.
module rr_pick
  import sig_acq_pkg::*;
#(
  parameter int N  = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  winner,
  output logic          found
);

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(last) + i) % N]) begin
        winner[(int'(last) + i) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Frame-level round-robin arbiter feeding the shared UART TX FIFO, one whole frame per grant.
// Define UART_TX_ARB_CHKSUM_EN to append a mod-256 checksum byte after every completed frame.
module uart_tx_arb
  import sig_acq_pkg::*;
#(
  parameter int          NUM_REQ    = 2,
  parameter int          FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int          MIN_FREE   = 8,
  parameter logic [15:0] TIMEOUT    = 16'd4096,
  localparam int         UW         = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_fifo_wen,
  output logic [7:0]             tx_fifo_wdata,
  input  logic                   tx_fifo_full,
  input  logic [UW-1:0]          tx_fifo_usedw,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   frame_abort
);

  localparam int            LW        = $clog2(NUM_REQ);
  localparam logic [UW-1:0] SPACE_MAX = UW'(FIFO_DEPTH - 3);
  localparam logic [UW-1:0] GRANT_MAX = UW'(FIFO_DEPTH - MIN_FREE);

  arb_state_t         state;
  logic [LW-1:0]      last;
  logic [LW-1:0]      win_idx;
  logic [NUM_REQ-1:0] winner;
  logic               found;
  logic [15:0]        tmo_cnt;
  logic               space_ok;
  logic               grant_ok;
  logic               valid_g;
  logic               last_g;
  logic [7:0]         data_g;
  logic               hs;
`ifdef UART_TX_ARB_CHKSUM_EN
  logic [7:0]         csum;
`endif

  rr_pick #(.N(NUM_REQ), .LW(LW)) u_pick (
    .req    (req_valid),
    .last   (last),
    .winner (winner),
    .found  (found)
  );

  // usedw wraps to 0 when the FIFO is completely full, so the full flag must gate both terms.
  assign space_ok  = !tx_fifo_full && (tx_fifo_usedw <= SPACE_MAX);
  assign grant_ok  = ena && found && !tx_fifo_full && (tx_fifo_usedw <= GRANT_MAX);
  assign req_ready = (state == ARB_SEND && space_ok && !tx_fifo_wen) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign busy      = (state != ARB_IDLE);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = LW'(i);
    end
  end

  always_comb begin
    data_g  = '0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        data_g  = req_data[8*i +: 8];
        valid_g = req_valid[i];
        last_g  = req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ARB_IDLE;
      grant         <= '0;
      last          <= LW'(NUM_REQ - 1);
      tmo_cnt       <= '0;
      tx_fifo_wen   <= 1'b0;
      tx_fifo_wdata <= '0;
      frame_abort   <= 1'b0;
`ifdef UART_TX_ARB_CHKSUM_EN
      csum          <= '0;
`endif
    end else begin
      tx_fifo_wen <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_ok) begin
            grant   <= winner;
            last    <= win_idx;
            tmo_cnt <= '0;
`ifdef UART_TX_ARB_CHKSUM_EN
            csum    <= '0;
`endif
            state   <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (hs) begin
            tx_fifo_wen   <= 1'b1;
            tx_fifo_wdata <= data_g;
            tmo_cnt       <= '0;
`ifdef UART_TX_ARB_CHKSUM_EN
            csum          <= csum + data_g;
            if (last_g) state <= ARB_CSUM;
`else
            if (last_g) begin
              state <= ARB_IDLE;
              grant <= '0;
            end
`endif
          end else if (!valid_g) begin
            // Abort registers on the cycle the counter reaches TIMEOUT; nothing is written.
            if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt + 16'd1 == TIMEOUT) begin
              frame_abort <= 1'b1;
              state       <= ARB_IDLE;
              grant       <= '0;
            end
          end
        end
`ifdef UART_TX_ARB_CHKSUM_EN
        ARB_CSUM: begin
          if (space_ok && !tx_fifo_wen) begin
            tx_fifo_wen   <= 1'b1;
            tx_fifo_wdata <= csum;
            state         <= ARB_IDLE;
            grant         <= '0;
          end
        end
`endif
        default: begin
          state <= ARB_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: queue-fed requesters, negedge monitor logs, per-scenario checks.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic        tx_fifo_wen;
  logic [7:0]  tx_fifo_wdata;
  logic        tx_fifo_full = 1'b0;
  logic [4:0]  tx_fifo_usedw = '0;
  logic [1:0]  grant;
  logic        busy;
  logic        frame_abort;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Each requester streams bytes from its queue; bit 8 marks the last byte of a frame.
  logic [8:0] src_q0[$];
  logic [8:0] src_q1[$];
  logic [1:0] pop_pend = '0;
  logic [1:0] prev_g = '0;

  logic [7:0] wr_q[$];
  int         wr_cq[$];
  int         hs_cq[$];
  logic [1:0] hs_rq[$];
  logic [1:0] gnt_q[$];
  int         ab_cq[$];

  uart_tx_arb dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_fifo_wen   (tx_fifo_wen),
    .tx_fifo_wdata (tx_fifo_wdata),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_usedw (tx_fifo_usedw),
    .grant         (grant),
    .busy          (busy),
    .frame_abort   (frame_abort)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- requester drivers ----------------
  always @(posedge clk) begin
    #1;
    if (pop_pend[0] && src_q0.size() > 0) src_q0.delete(0);
    if (pop_pend[1] && src_q1.size() > 0) src_q1.delete(0);
    if (src_q0.size() > 0) begin
      req_valid[0]  = 1'b1;
      req_data[7:0] = src_q0[0][7:0];
      req_last[0]   = src_q0[0][8];
    end else begin
      req_valid[0] = 1'b0;
      req_last[0]  = 1'b0;
    end
    if (src_q1.size() > 0) begin
      req_valid[1]   = 1'b1;
      req_data[15:8] = src_q1[0][7:0];
      req_last[1]    = src_q1[0][8];
    end else begin
      req_valid[1] = 1'b0;
      req_last[1]  = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    pop_pend = req_valid & req_ready;
    if (pop_pend != 2'b00) begin
      hs_cq.push_back(cyc_n);
      hs_rq.push_back(pop_pend);
    end
    if (tx_fifo_wen) begin
      wr_q.push_back(tx_fifo_wdata);
      wr_cq.push_back(cyc_n);
    end
    if (grant != 2'b00 && prev_g == 2'b00) gnt_q.push_back(grant);
    prev_g = grant;
    if (frame_abort) ab_cq.push_back(cyc_n);
  end

  // ---------------- helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc_n < c) next_cycle();
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_cq.delete();
    hs_cq.delete();
    hs_rq.delete();
    gnt_q.delete();
    ab_cq.delete();
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      @(negedge clk);
      n++;
      done = (src_q0.size() == 0) && (src_q1.size() == 0) && !busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle: still busy after %0d cycles, required idle", name, max_cyc);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rst_ready: got %b required 00", req_ready); end
    checks++; if (tx_fifo_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %b required 0", tx_fifo_wen); end
    checks++; if (tx_fifo_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h required 00", tx_fifo_wdata); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b required 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (frame_abort !== 1'b0) begin errors++; $display("FAIL rst_abort: got %b required 0", frame_abort); end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_d[$];
    int exp_c[$];
    int p;
    clear_logs();
    @(negedge clk);
    src_q0.push_back(9'h055);
    src_q0.push_back(9'h0AA);
    src_q0.push_back(9'h101);
    p = cyc_n;
    // valid appears at p+1, grant at p+2, handshakes every other cycle, writes one cycle later
    exp_d = '{8'h55, 8'hAA, 8'h01};
    exp_c = '{p + 3, p + 5, p + 7};
`ifdef UART_TX_ARB_CHKSUM_EN
    exp_d.push_back(8'h00);
    exp_c.push_back(p + 9);
`endif
    wait_idle(60, "single");
    checks++; if (wr_q.size() != exp_d.size()) begin errors++; $display("FAIL single_count: got %0d writes required %0d", wr_q.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_d[i]) begin errors++; $display("FAIL single_data[%0d]: got %h required %h", i, wr_q[i], exp_d[i]); end
      checks++; if (wr_cq[i] != exp_c[i]) begin errors++; $display("FAIL single_wcyc[%0d]: got %0d required %0d", i, wr_cq[i], exp_c[i]); end
    end
    checks++; if (hs_cq.size() != 3 || hs_cq[0] != p + 2) begin errors++; $display("FAIL single_hs: got %0d handshakes required 3 starting at %0d", hs_cq.size(), p + 2); end
    checks++; if (gnt_q.size() != 1 || gnt_q[0] !== 2'b01) begin errors++; $display("FAIL single_grant: got %0d grants required one grant of 01", gnt_q.size()); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d[$];
    logic [1:0] exp_g[$];
    logic [1:0] exp_h[$];
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    src_q0.push_back(9'h010); src_q0.push_back(9'h111);
    src_q0.push_back(9'h012); src_q0.push_back(9'h113);
    src_q1.push_back(9'h020); src_q1.push_back(9'h121);
    src_q1.push_back(9'h022); src_q1.push_back(9'h123);
`ifdef UART_TX_ARB_CHKSUM_EN
    exp_d = '{8'h10, 8'h11, 8'h21, 8'h20, 8'h21, 8'h41, 8'h12, 8'h13, 8'h25, 8'h22, 8'h23, 8'h45};
`else
    exp_d = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23};
`endif
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_h = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    wait_idle(120, "rr");
    checks++; if (gnt_q.size() != 4) begin errors++; $display("FAIL rr_grant_count: got %0d required 4", gnt_q.size()); end
    for (int i = 0; i < 4 && i < gnt_q.size(); i++) begin
      checks++; if (gnt_q[i] !== exp_g[i]) begin errors++; $display("FAIL rr_grant[%0d]: got %b required %b", i, gnt_q[i], exp_g[i]); end
    end
    checks++; if (hs_rq.size() != 8) begin errors++; $display("FAIL rr_hs_count: got %0d required 8", hs_rq.size()); end
    for (int i = 0; i < 8 && i < hs_rq.size(); i++) begin
      checks++; if (hs_rq[i] !== exp_h[i]) begin errors++; $display("FAIL rr_hs_owner[%0d]: got %b required %b", i, hs_rq[i], exp_h[i]); end
    end
    checks++; if (wr_q.size() != exp_d.size()) begin errors++; $display("FAIL rr_count: got %0d required %0d", wr_q.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_d[i]) begin errors++; $display("FAIL rr_data[%0d]: got %h required %h", i, wr_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d[$];
    int exp_c[$];
    int p;
    int x;
    clear_logs();
    @(negedge clk);
    src_q0.push_back(9'h031);
    src_q0.push_back(9'h132);
    p = cyc_n;
    wait_until(p + 3);
    tx_fifo_usedw = 5'd30;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_hold[%0d]: got %b required 00", k, req_ready); end
    end
    next_cycle();
    tx_fifo_usedw = 5'd29;
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL bp_release: got %b required 01", req_ready); end
    exp_d = '{8'h31, 8'h32};
    exp_c = '{p + 3, p + 9};
`ifdef UART_TX_ARB_CHKSUM_EN
    exp_d.push_back(8'h63);
    exp_c.push_back(p + 11);
`endif
    wait_idle(60, "bp");
    checks++; if (wr_q.size() != exp_d.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", wr_q.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_d[i] || wr_cq[i] != exp_c[i]) begin errors++; $display("FAIL bp_write[%0d]: got %h at %0d required %h at %0d", i, wr_q[i], wr_cq[i], exp_d[i], exp_c[i]); end
    end

    // Grant threshold: 25 used words leaves fewer than MIN_FREE free.
    clear_logs();
    tx_fifo_usedw = 5'd25;
    @(negedge clk);
    src_q1.push_back(9'h041);
    src_q1.push_back(9'h142);
    repeat (6) next_cycle();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL bp_no_grant: got grant %b busy %b required 00 0", grant, busy); end
    checks++; if (hs_cq.size() != 0) begin errors++; $display("FAIL bp_no_hs: got %0d handshakes required 0", hs_cq.size()); end
    tx_fifo_usedw = 5'd24;
    x = cyc_n;
    next_cycle();
    @(negedge clk);
    checks++; if (grant !== 2'b10 || cyc_n != x + 1) begin errors++; $display("FAIL bp_grant: got %b required 10", grant); end
    wait_idle(60, "bp2");
    tx_fifo_usedw = 5'd0;
    checks++; if (wr_q.size() < 2 || wr_q[0] !== 8'h41 || wr_q[1] !== 8'h42) begin errors++; $display("FAIL bp2_data: got %0d writes required 41 42 first", wr_q.size()); end
  endtask

  task automatic test_full_wrap();
    clear_logs();
    tx_fifo_full  = 1'b1;
    tx_fifo_usedw = 5'd0;
    @(negedge clk);
    src_q0.push_back(9'h051);
    src_q0.push_back(9'h152);
    repeat (6) next_cycle();
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL full_no_grant: got grant %b busy %b required 00 0", grant, busy); end
    checks++; if (hs_cq.size() != 0 || req_ready !== 2'b00) begin errors++; $display("FAIL full_no_hs: got %0d handshakes ready %b required 0 00", hs_cq.size(), req_ready); end
    tx_fifo_full = 1'b0;
    next_cycle();
    next_cycle();
    tx_fifo_full = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_send_ready: got %b required 00", req_ready); end
    next_cycle();
    tx_fifo_full = 1'b0;
    wait_idle(60, "full");
    checks++; if (wr_q.size() < 2 || wr_q[0] !== 8'h51 || wr_q[1] !== 8'h52) begin errors++; $display("FAIL full_data: got %0d writes required 51 52 first", wr_q.size()); end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_d[$];
    int p;
    clear_logs();
    @(negedge clk);
    src_q1.push_back(9'h066);
    p = cyc_n;
    wait_idle(4400, "tmo");
    // handshake at p+2; abort lands 4097 cycles later, state already IDLE
    checks++; if (hs_cq.size() != 1 || hs_cq[0] != p + 2) begin errors++; $display("FAIL tmo_hs: got %0d handshakes required one at %0d", hs_cq.size(), p + 2); end
    checks++; if (ab_cq.size() != 1 || ab_cq[0] != p + 4099) begin errors++; $display("FAIL tmo_abort: got %0d pulses (first %0d) required one at %0d", ab_cq.size(), (ab_cq.size() > 0) ? ab_cq[0] : -1, p + 4099); end
    checks++; if (cyc_n - 1 != p + 4099) begin errors++; $display("FAIL tmo_idle: got idle at %0d required %0d", cyc_n - 1, p + 4099); end
    checks++; if (wr_q.size() != 1 || wr_q[0] !== 8'h66) begin errors++; $display("FAIL tmo_writes: got %0d writes required one of 66", wr_q.size()); end

    clear_logs();
    @(negedge clk);
    src_q0.push_back(9'h070); src_q0.push_back(9'h171);
    src_q1.push_back(9'h080); src_q1.push_back(9'h181);
`ifdef UART_TX_ARB_CHKSUM_EN
    exp_d = '{8'h70, 8'h71, 8'hE1, 8'h80, 8'h81, 8'h01};
`else
    exp_d = '{8'h70, 8'h71, 8'h80, 8'h81};
`endif
    wait_idle(60, "tmo_next");
    checks++; if (gnt_q.size() != 2 || gnt_q[0] !== 2'b01 || gnt_q[1] !== 2'b10) begin errors++; $display("FAIL tmo_next_grant: got %0d grants (first %b) required 01 then 10", gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : 2'bxx); end
    checks++; if (wr_q.size() != exp_d.size()) begin errors++; $display("FAIL tmo_next_count: got %0d required %0d", wr_q.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_d[i]) begin errors++; $display("FAIL tmo_next_data[%0d]: got %h required %h", i, wr_q[i], exp_d[i]); end
    end
  endtask

  task automatic test_ena_reset();
    logic [7:0] exp_d[$];
    int p;
    clear_logs();
    @(negedge clk);
    src_q0.push_back(9'h090); src_q0.push_back(9'h091); src_q0.push_back(9'h192);
    src_q1.push_back(9'h0A0); src_q1.push_back(9'h1A1);
    p = cyc_n;
    wait_until(p + 3);
    ena = 1'b0;
    repeat (20) next_cycle();
`ifdef UART_TX_ARB_CHKSUM_EN
    exp_d = '{8'h90, 8'h91, 8'h92, 8'hB3};
`else
    exp_d = '{8'h90, 8'h91, 8'h92};
`endif
    checks++; if (wr_q.size() != exp_d.size()) begin errors++; $display("FAIL ena_count: got %0d required %0d", wr_q.size(), exp_d.size()); end
    for (int i = 0; i < exp_d.size() && i < wr_q.size(); i++) begin
      checks++; if (wr_q[i] !== exp_d[i]) begin errors++; $display("FAIL ena_data[%0d]: got %h required %h", i, wr_q[i], exp_d[i]); end
    end
    checks++; if (busy !== 1'b0 || grant !== 2'b00 || src_q1.size() != 2) begin errors++; $display("FAIL ena_hold: got busy %b grant %b pending %0d required 0 00 2", busy, grant, src_q1.size()); end
    ena = 1'b1;
    wait_idle(60, "ena");
    checks++; if (wr_q.size() < exp_d.size() + 2 || wr_q[exp_d.size()] !== 8'hA0 || wr_q[exp_d.size() + 1] !== 8'hA1) begin errors++; $display("FAIL ena_resume: got %0d writes required A0 A1 after first frame", wr_q.size()); end

    clear_logs();
    @(negedge clk);
    src_q0.push_back(9'h0B0); src_q0.push_back(9'h0B1); src_q0.push_back(9'h1B2);
    p = cyc_n;
    wait_until(p + 3);
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++; if (req_ready !== 2'b00 || tx_fifo_wen !== 1'b0 || tx_fifo_wdata !== 8'h00) begin errors++; $display("FAIL mid_rst_fifo: got ready %b wen %b wdata %h required 00 0 00", req_ready, tx_fifo_wen, tx_fifo_wdata); end
    checks++; if (grant !== 2'b00 || busy !== 1'b0 || frame_abort !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl: got grant %b busy %b abort %b required 00 0 0", grant, busy, frame_abort); end
    src_q0.delete();
    next_cycle();
    rst = 1'b0;
    repeat (5) next_cycle();
    checks++; if (wr_q.size() != 1 || wr_q[0] !== 8'hB0) begin errors++; $display("FAIL mid_rst_partial: got %0d writes required one of B0", wr_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_full_wrap();
    test_timeout();
    test_ena_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
